// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage for a 24-bit ISA.
// Issues reads to a one-cycle-latency instruction memory and presents the
// returned word to decode with a valid/ready handshake. It handles stalls,
// halt, and same-cycle redirect (flush and refetch).
// Optional build macro FETCH_PERF_CNT_EN adds the saturating counters
// fetch_cnt and stall_cnt.
module fetch_unit #(
  parameter logic [23:0] RESET_PC = 24'h000000,
  parameter logic [23:0] PC_STEP  = 24'd3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [23:0] imem_addr,
  output logic        imem_en,
  input  logic [23:0] imem_data,
  input  logic        halt,
  input  logic        redirect,
  input  logic [23:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [23:0] id_instr,
  output logic [23:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [23:0] fetch_cnt,
  output logic [23:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [23:0] inflightPc_q, inflightPc_d;
  logic        issue;

  // Fetch issue decision: a redirect always refetches, otherwise issue only when running and the output slot frees up.
  always_comb begin
    issue = 1'b0;
    if (!rst) begin
      if (redirect && (state_q == RUN || state_q == HALTED)) begin
        issue = 1'b1;
      end else if (state_q == RUN && !halt && (!inflight_q || id_ready)) begin
        issue = 1'b1;
      end
    end
  end

  assign imem_en   = issue;
  assign imem_addr = redirect ? redirect_pc : pc_q;

  assign id_valid  = inflight_q;
  assign id_instr  = imem_data;
  assign id_pc     = inflightPc_q;

  // Control FSM next state: leave IDLE right after reset, halt stops issue, and only a redirect resumes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt && !redirect) state_d = HALTED;
      HALTED:  if (redirect) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next fetch address and in-flight tracking: a new issue replaces the slot, and an accepted word empties it.
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    inflightPc_d = inflightPc_q;
    if (issue) begin
      pc_d         = imem_addr + PC_STEP;
      inflight_d   = 1'b1;
      inflightPc_d = imem_addr;
    end else if (id_ready) begin
      inflight_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= 24'h000000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [23:0] fetchCnt_q, fetchCnt_d;
  logic [23:0] stallCnt_q, stallCnt_d;

  // Saturating counters: issued fetches, and cycles where decode refused a valid word.
  always_comb begin
    fetchCnt_d = fetchCnt_q;
    stallCnt_d = stallCnt_q;
    if (issue && fetchCnt_q != 24'hFFFFFF) begin
      fetchCnt_d = fetchCnt_q + 24'd1;
    end
    if (inflight_q && !id_ready && stallCnt_q != 24'hFFFFFF) begin
      stallCnt_d = stallCnt_q + 24'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCnt_q <= 24'h000000;
      stallCnt_q <= 24'h000000;
    end else begin
      fetchCnt_q <= fetchCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign fetch_cnt = fetchCnt_q;
  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter RESET_PC, default 24'h000000: PC loaded on reset.
REQ-003 Parameter PC_STEP, default 3: byte increment between sequential 24-bit instructions.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- imem_addr  out  24  instruction memory byte address
- imem_en  out  1  instruction memory read enable
- imem_data  in  24  instruction memory output; valid 1 cycle after an enabled read; held while imem_en=0
- halt  in  1  stop issuing fetches after the current one
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  24  target address qualified by redirect
- id_ready  in  1  decode stage accepts id_instr this cycle
- id_valid  out  1  id_instr/id_pc hold a fetched instruction
- id_instr  out  24  instruction to decode (opcode 21:17, rd 15:13, rs 12:10, rt 9:7, cond 23:22, set_flag 16)
- id_pc  out  24  byte address of id_instr

Function
REQ-005 State machine states SHALL be IDLE, RUN and HALTED.
REQ-006 Transitions: IDLE->RUN unconditionally on the first non-reset cycle; RUN->HALTED when halt=1 and redirect=0; HALTED->RUN only on redirect=1; any state->IDLE on rst.
REQ-007 Internal registers SHALL be pc_q (next fetch address), inflight (a read was issued last cycle), and inflight_pc.
REQ-008 The issue condition SHALL be: state RUN, halt=0, and (inflight=0 or id_ready=1).
- Alternatively, redirect=1 in RUN or HALTED.
REQ-009 imem_en SHALL equal the issue condition, combinationally.
- imem_addr SHALL be redirect_pc when redirect=1, otherwise pc_q.
REQ-010 On issue, the block SHALL load pc_q with imem_addr+PC_STEP, set inflight to 1, and load inflight_pc with imem_addr.
REQ-011 With no issue, inflight SHALL clear when id_ready=1; otherwise inflight and pc_q SHALL hold (stall).
REQ-012 Output mapping: id_valid = inflight; id_instr = imem_data; id_pc = inflight_pc.
- Fetch-to-id_valid latency SHALL be exactly 1 cycle.
REQ-013 A transfer SHALL occur when id_valid=1, id_ready=1 and redirect=0.
- Sustained throughput SHALL be 1 instruction/cycle.
REQ-014 On redirect=1, the instruction presented that cycle SHALL be discarded regardless of id_ready.
- The target fetch SHALL issue in the same cycle; the first target instruction appears the next cycle.
REQ-015 redirect SHALL take priority over halt and over stall in the same cycle.
REQ-016 PC arithmetic SHALL be modulo 2^24.
- Example: pc_q 24'hFFFFFD + 3 -> 24'h000000, with no error flag.
REQ-017 When halt is asserted, an instruction already in flight SHALL still be presented and held until it transfers.

Reset
REQ-018 While rst=1, the block SHALL drive imem_en=0.
- It SHALL load pc_q=RESET_PC, inflight=0, inflight_pc=0 and state=IDLE; id_valid=0 from the next cycle.
REQ-019 A reset mid-stall or mid-redirect SHALL discard the in-flight instruction.
- The first post-reset fetch address SHALL be RESET_PC.

Configuration
REQ-020 Macro FETCH_PERF_CNT_EN SHALL control the performance counters.
- Defined: add outputs fetch_cnt[23:0] (increments per issue) and stall_cnt[23:0] (increments per cycle with id_valid=1 and id_ready=0).
- Both counters SHALL saturate at 24'hFFFFFF and clear on rst.
- Undefined: these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Bench memory SHALL be preloaded with DEADBE@0, FEEDBA@3, ABCDEF@6, C0FFEE@9, BEEFCA@12.
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then id_ready=1 -> imem_addr 0,3,6,9 on consecutive cycles; id_instr DEADBE, FEEDBA, ABCDEF, C0FFEE with id_pc 0,3,6,9, one cycle after each.
- id_ready=0 for 3 cycles while FEEDBA is presented -> id_valid held, id_instr=FEEDBA, imem_en=0, pc_q=6 unchanged; with FETCH_PERF_CNT_EN, stall_cnt=3.
- redirect=1, redirect_pc=12 while ABCDEF is presented with id_ready=1 -> ABCDEF not transferred; next cycle id_instr=BEEFCA, id_pc=12; following imem_addr=15.
- halt=1 in RUN -> imem_en=0 from that cycle; pending instruction transfers, then id_valid=0; redirect to 3 -> FEEDBA presented next cycle.
- RESET_PC=24'hFFFFFD -> after first fetch, imem_addr=24'h000000.
- rst=1 during a stall -> id_valid=0 next cycle; first post-reset imem_addr=RESET_PC.
